csa_sub16_seq: RTL and testbench
================================

Name: csa_sub16_seq

Overview:
- Sequential 16-bit subtractor computing d = a - b - bin. Built as the inverse-direction companion to the team's carry-select adders.
- Processes one M-bit block per clock. Each block uses a carry-select pair (precomputed with carry 0 and carry 1), and the registered block carry picks the result.
- Sits between operand producers and result consumers behind valid/ready handshakes.
- Reports borrow-out and signed overflow.

Parameters:
N, 16, operand/result width; must be an integer multiple of M
M, 4, block width processed per CALC cycle; N/M >= 2
NB, N/M, number of blocks (localparam, not overridable)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, bin are valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  minuend
b  input  N  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result d, bout, ovf are valid
out_ready  input  1  consumer accepts the result
d  output  N  difference a - b - bin, mod 2^N
bout  output  1  borrow-out; 1 when the unsigned result a < b + bin
ovf  output  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; blk = 0; carry = 0; d = 0; bout = 0; ovf = 0; out_valid = 0; captured operands = 0. in_ready = 1 once rst_n is high.
- Arithmetic: a - b - bin is computed as a + ~b + ~bin. The initial carry register is ~bin.
- Per block i: s0 = a[i] + ~b[i] + 0 and s1 = a[i] + ~b[i] + 1, each (M+1) bits wide. The sum and carry-out of s1 are selected when carry = 1, otherwise those of s0.
- FSM IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid at a rising edge: register a, ~b and carry = ~bin; set blk = 0; go to CALC.
- FSM CALC:
  - in_ready = 0, out_valid = 0.
  - Each cycle: write the selected M-bit sum into d[blk*M +: M], update carry with the selected carry-out, blk++.
  - The edge that processes blk = NB-1 moves to HOLD. On that same edge: bout = ~final carry; ovf = (a[N-1] != b[N-1]) && (d_new[N-1] != a[N-1]).
- FSM HOLD:
  - out_valid = 1; d, bout, ovf stay stable.
  - On out_ready at a rising edge: out_valid clears, go to IDLE.
- Latency: operands accepted at edge k; out_valid is high after edge k+NB (k+4 at defaults).
- Throughput: at best one operation per NB+2 cycles. No IDLE bypass from HOLD; in_ready rises the cycle after out_ready is taken.
- in_valid outside IDLE is ignored; a, b and bin may change freely after acceptance.
- out_ready outside HOLD has no effect.
- d keeps its last result after leaving HOLD. The partial d during CALC is undefined to observers and must not be relied on.
- Reset asserted mid-CALC or during HOLD aborts the operation immediately. No out_valid pulse follows.
- blk wraps only via the FSM. It never indexes beyond NB-1.

Test Plan:
- a=0x1234, b=0x0234, bin=0 -> after 4 CALC cycles out_valid=1, d=0x1000, bout=0, ovf=0.
- a=0x1000, b=0x0001, bin=0 (borrow ripples through 3 blocks) -> d=0x0FFF, bout=0, ovf=0. Also a=0x0000, b=0x0001 -> d=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, ovf=1, bout=0. Also a=0x7FFF, b=0xFFFF -> d=0x8000, ovf=1, bout=1.
- a=0x0005, b=0x0003, bin=1 -> d=0x0001, bout=0. Also a=0x0000, b=0x0000, bin=1 -> d=0xFFFF, bout=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid rises -> d, bout and ovf stay stable and in_ready stays 0.
  - Toggle in_valid with new operands during HOLD -> they are ignored.
  - Then out_ready=1 for 1 cycle -> IDLE, in_ready=1 the next cycle.
- Reset:
  - Assert rst_n=0 in the 2nd CALC cycle -> out_valid=0, d=0, in_ready=1 after release.
  - The next operation (a=0xFFFF, b=0x0001) -> d=0xFFFE, bout=0.

Source files
------------

// File: rtl/csa_sub16_seq.sv
// Sequential N-bit subtractor d = a - b - bin, one M-bit carry-select block per clock.
// Operands are captured in IDLE, blocks are resolved LSB-first in CALC, and the result is held until taken.
module csa_sub16_seq #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf
);

  localparam int NB = N / M;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_q;
  logic [N-1:0]   nb_q;
  logic           carry;
  logic [BW-1:0]  blk;

  logic [M-1:0]   a_blk;
  logic [M-1:0]   nb_blk;
  logic [M:0]     s0;
  logic [M:0]     s1;
  logic [M:0]     sel;
  logic [N-1:0]   d_new;
  logic           last_blk;
  logic           accept;

  // Carry-select pair for the current block; the registered carry picks one.
  always_comb begin
    a_blk    = a_q[int'(blk)*M +: M];
    nb_blk   = nb_q[int'(blk)*M +: M];
    s0       = {1'b0, a_blk} + {1'b0, nb_blk};
    s1       = {1'b0, a_blk} + {1'b0, nb_blk} + {{M{1'b0}}, 1'b1};
    sel      = carry ? s1 : s0;
    d_new    = d;
    d_new[int'(blk)*M +: M] = sel[M-1:0];
    last_blk = (blk == BW'(NB - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_blk) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  // Subtraction runs as a + ~b + ~bin, so b is stored inverted and the carry seeds with ~bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      nb_q  <= '0;
      carry <= 1'b0;
      blk   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      nb_q  <= ~b;
      carry <= ~bin;
      blk   <= '0;
    end else if (state == CALC) begin
      d     <= d_new;
      carry <= sel[M];
      if (last_blk) begin
        blk  <= '0;
        bout <= ~sel[M];
        // Operand signs differ (a vs b, i.e. a equals ~b) and the result sign departs from a.
        ovf  <= (a_q[N-1] == nb_q[N-1]) && (d_new[N-1] != a_q[N-1]);
      end else begin
        blk  <= blk + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_csa_sub16_seq.sv
// Scoreboard bench for csa_sub16_seq: driver pushes expected results, a negedge monitor pops on handshake.
module tb_csa_sub16_seq;
  localparam int N  = 16;
  localparam int M  = 4;
  localparam int NB = N / M;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] d;
  logic         bout;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bp_mode = 0;
  logic [N+1:0] sb_q[$];
  int           lat_q[$];
  logic         prev_valid = 1'b0;

  csa_sub16_seq #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction; packed as {ovf, bout, d}.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] u;
    int s;
    logic ov;
    u  = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    s  = int'($signed(x)) - int'($signed(y)) - int'(c);
    ov = (s > 32767) || (s < -32768);
    return {ov, u[N], u[N-1:0]};
  endfunction

  // out_ready: 0 = always ready, 1 = random backpressure, 2 = driven by the main sequence
  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [N+1:0] e;
    int k;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) check("unexpected_out_valid", 32'(1), 32'(0));
        else begin
          k = lat_q.pop_front();
          check("latency", 32'(cyc - k), 32'(NB));
        end
      end
      if (out_valid) check("in_ready_in_hold", 32'(in_ready), 32'(0));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 32'(1), 32'(0));
        else begin
          e = sb_q.pop_front();
          check("result_d", 32'(d), 32'(e[N-1:0]));
          check("result_bout", 32'(bout), 32'(e[N]));
          check("result_ovf", 32'(ovf), 32'(e[N+1]));
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic c,
                       input logic [N+1:0] exp, input bit track);
    int w;
    w = 0;
    @(negedge clk);
    a = x; b = y; bin = c; in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
    if (track) begin
      sb_q.push_back(exp);
      lat_q.push_back(cyc);
    end
    @(negedge clk);
    check("in_ready_calc", 32'(in_ready), 32'(0));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || out_valid) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    logic [N-1:0] x, y;
    logic c;
    logic [N+1:0] e;
    int w;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_d", 32'(d), 32'(0));
    check("rst_bout", 32'(bout), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Directed vectors with hand-derived results
    issue(16'h1234, 16'h0234, 1'b0, {1'b0, 1'b0, 16'h1000}, 1'b1);
    issue(16'h1000, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0FFF}, 1'b1);
    issue(16'h0000, 16'h0001, 1'b0, {1'b0, 1'b1, 16'hFFFF}, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h7FFF}, 1'b1);
    issue(16'h7FFF, 16'hFFFF, 1'b0, {1'b1, 1'b1, 16'h8000}, 1'b1);
    issue(16'h0005, 16'h0003, 1'b1, {1'b0, 1'b0, 16'h0001}, 1'b1);
    issue(16'h0000, 16'h0000, 1'b1, {1'b0, 1'b1, 16'hFFFF}, 1'b1);
    drain();

    // Random operands under random backpressure
    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      x = N'($urandom); y = N'($urandom); c = 1'($urandom);
      if (i % 10 == 0) x = {1'b1, {(N-1){1'b0}}};
      if (i % 10 == 5) y = {1'b0, {(N-1){1'b1}}};
      issue(x, y, c, model(x, y, c), 1'b1);
    end
    drain();

    // Held result must stay stable and ignore new operands
    bp_mode = 2;
    out_ready = 1'b0;
    e = model(16'hA5C3, 16'h3C5A, 1'b1);
    issue(16'hA5C3, 16'h3C5A, 1'b1, e, 1'b1);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("hold_reached", 32'(out_valid), 32'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_d", 32'(d), 32'(e[N-1:0]));
      check("hold_bout", 32'(bout), 32'(e[N]));
      check("hold_ovf", 32'(ovf), 32'(e[N+1]));
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'(1));
    check("release_out_valid", 32'(out_valid), 32'(0));
    bp_mode = 0;
    check("hold_sb_empty", 32'(sb_q.size()), 32'(0));

    // Reset in the second CALC cycle aborts the operation
    issue(16'h1357, 16'h0246, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_d", 32'(d), 32'(0));
    check("abort_bout", 32'(bout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_no_valid", 32'(out_valid), 32'(0));
    repeat (6) @(negedge clk);
    issue(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'hFFFE}, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
